escape_host: RTL and testbench

ESCAPE_HOST -- requirements
Module: escape_host

---
 rtl/escape_host.sv | 133 +++++++++++++
 tb/tb_escape_host.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/escape_host.sv
// rtl/escape_host.sv - escape-room quiz host: asks questions, judges answers, tracks lives and score

module escape_host #(
    parameter int NUM_Q   = 6,
    parameter int TIMEOUT = 16,
    parameter int LIVES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ans_valid,
    input  logic [1:0] ans_data,
    output logic       ans_ready,
    output logic [2:0] q_idx,
    output logic       q_valid,
    output logic [1:0] lives,
    output logic [3:0] score,
    output logic       busy,
    output logic       solved,
    output logic       failed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK,
        S_JUDGE,
        S_SOLVED,
        S_FAILED
    } state_t;

    // Bit i holds the correct answer to question i (q0 in bit 0).
    localparam logic [7:0] KEY        = 8'b0100_1101;
    localparam logic [2:0] LAST_Q     = 3'(NUM_Q - 1);
    localparam logic [7:0] LAST_T     = 8'(TIMEOUT - 1);
    localparam logic [1:0] FULL_LIVES = 2'(LIVES);

    state_t      r_state, w_state;
    logic [2:0]  r_q_idx, w_q_idx;
    logic [1:0]  r_lives, w_lives;
    logic [3:0]  r_score, w_score;
    logic [7:0]  r_timer, w_timer;
    logic        r_miss, w_miss;
    logic [1:0]  r_ans, w_ans;
    logic        w_handshake;
    logic        w_correct;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q_idx <= 3'd0;
            r_lives <= FULL_LIVES;
            r_score <= 4'd0;
            r_timer <= 8'd0;
            r_miss  <= 1'b0;
            r_ans   <= 2'd0;
        end else begin
            r_state <= w_state;
            r_q_idx <= w_q_idx;
            r_lives <= w_lives;
            r_score <= w_score;
            r_timer <= w_timer;
            r_miss  <= w_miss;
            r_ans   <= w_ans;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_q_idx     = r_q_idx;
        w_lives     = r_lives;
        w_score     = r_score;
        w_timer     = r_timer;
        w_miss      = r_miss;
        w_ans       = r_ans;
        w_handshake = (r_state == S_ASK) && ans_valid;
        w_correct   = !r_miss && (r_ans == {1'b0, KEY[r_q_idx]});

        unique case (r_state)
            S_IDLE, S_SOLVED, S_FAILED: begin
                if (start) begin
                    w_state = S_ASK;
                    w_q_idx = 3'd0;
                    w_lives = FULL_LIVES;
                    w_score = 4'd0;
                    w_timer = 8'd0;
                end
            end
            S_ASK: begin
                w_timer = r_timer + 8'd1;
                // A handshake on the last allowed cycle still counts as an answer.
                if (w_handshake) begin
                    w_ans   = ans_data;
                    w_miss  = 1'b0;
                    w_state = S_JUDGE;
                end else if (r_timer == LAST_T) begin
                    w_miss  = 1'b1;
                    w_state = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (w_correct) begin
                    w_score = (r_score == 4'd15) ? r_score : r_score + 4'd1;
                    if (r_q_idx == LAST_Q) begin
                        w_state = S_SOLVED;
                    end else begin
                        w_q_idx = r_q_idx + 3'd1;
                        w_timer = 8'd0;
                        w_state = S_ASK;
                    end
                end else begin
                    w_lives = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                    if (r_lives <= 2'd1) begin
                        w_state = S_FAILED;
                    end else begin
                        w_timer = 8'd0;
                        w_state = S_ASK;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign ans_ready = (r_state == S_ASK);
    assign q_valid   = (r_state == S_ASK);
    assign busy      = (r_state == S_ASK) || (r_state == S_JUDGE);
    assign solved    = (r_state == S_SOLVED);
    assign failed    = (r_state == S_FAILED);
    assign q_idx     = r_q_idx;
    assign lives     = r_lives;
    assign score     = r_score;

endmodule

// File: tb/tb_escape_host.sv
// tb/tb_escape_host.sv - randomized self-checking bench for escape_host against a game-level model

module tb_escape_host;

    localparam int NUM_Q   = 6;
    localparam int TIMEOUT = 16;
    localparam int LIVES   = 3;

    localparam int M_IDLE   = 0;
    localparam int M_ASK    = 1;
    localparam int M_JUDGE  = 2;
    localparam int M_SOLVED = 3;
    localparam int M_FAILED = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ans_valid;
    logic [1:0] ans_data;
    logic       ans_ready;
    logic [2:0] q_idx;
    logic       q_valid;
    logic [1:0] lives;
    logic [3:0] score;
    logic       busy;
    logic       solved;
    logic       failed;

    int key [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

    int n_checks = 0;
    int n_pass   = 0;

    // Game-level model: which question, lives left, score, and game status.
    int m_q, m_lives, m_score, m_mode;

    logic [13:0] obs;
    logic [13:0] exp_v;

    escape_host #(.NUM_Q(NUM_Q), .TIMEOUT(TIMEOUT), .LIVES(LIVES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ans_valid (ans_valid),
        .ans_data  (ans_data),
        .ans_ready (ans_ready),
        .q_idx     (q_idx),
        .q_valid   (q_valid),
        .lives     (lives),
        .score     (score),
        .busy      (busy),
        .solved    (solved),
        .failed    (failed)
    );

    always #5 clk = ~clk;

    assign obs = {ans_ready, q_valid, busy, solved, failed, q_idx, lives, score};

    function automatic logic [13:0] exp_vec(input int mode, input int q, input int l, input int s);
        logic [4:0] f;
        case (mode)
            M_ASK:    f = 5'b11100;
            M_JUDGE:  f = 5'b00100;
            M_SOLVED: f = 5'b00010;
            M_FAILED: f = 5'b00001;
            default:  f = 5'b00000;
        endcase
        return {f, 3'(q), 2'(l), 4'(s)};
    endfunction

    task automatic start_game(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_q = 0; m_lives = LIVES; m_score = 0; m_mode = M_ASK;
        exp_v = exp_vec(M_ASK, 0, LIVES, 0);
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s_start: got %h expected %h", name, obs, exp_v);
        else n_pass++;
    endtask

    // Entered at the first ASK cycle of an attempt; leaves at the cycle after the verdict.
    task automatic do_attempt(input string name, input bit to, input int dly, input logic [1:0] val);
        int n_ask;
        bit correct;
        n_ask = to ? TIMEOUT : dly + 1;
        for (int i = 0; i < n_ask; i++) begin
            ans_valid = !to && (i == n_ask - 1);
            ans_data  = ans_valid ? val : 2'($urandom);
            if (i == n_ask - 1) begin
                exp_v = exp_vec(M_ASK, m_q, m_lives, m_score);
                n_checks++;
                if (obs !== exp_v) $display("FAIL %s_ask: got %h expected %h", name, obs, exp_v);
                else n_pass++;
            end
            @(negedge clk);
        end
        exp_v = exp_vec(M_JUDGE, m_q, m_lives, m_score);
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s_judge: got %h expected %h", name, obs, exp_v);
        else n_pass++;
        ans_valid = 1'($urandom);
        ans_data  = 2'($urandom);
        @(negedge clk);
        ans_valid = 1'b0;
        correct = !to && (int'(val) == key[m_q]);
        if (correct) begin
            m_score = (m_score < 15) ? m_score + 1 : 15;
            if (m_q == NUM_Q - 1) m_mode = M_SOLVED;
            else m_q++;
        end else begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            if (m_lives == 0) m_mode = M_FAILED;
        end
        exp_v = exp_vec(m_mode, m_q, m_lives, m_score);
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s_verdict: got %h expected %h", name, obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset();
        start = 1'b1; ans_valid = 1'b1; ans_data = 2'd1; reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_v = exp_vec(M_IDLE, 0, LIVES, 0);
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        else n_pass++;
        reset = 1'b0; start = 1'b0; ans_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_idle_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_perfect_game();
        start_game("perfect");
        for (int q = 0; q < NUM_Q; q++) do_attempt("perfect", 1'b0, 0, 2'(key[q]));
        exp_v = exp_vec(M_SOLVED, NUM_Q - 1, LIVES, NUM_Q);
        n_checks++;
        if (obs !== exp_v) $display("FAIL perfect_solved: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_restart_from_solved();
        repeat (3) @(negedge clk);
        exp_v = exp_vec(M_SOLVED, NUM_Q - 1, LIVES, NUM_Q);
        n_checks++;
        if (obs !== exp_v) $display("FAIL solved_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
        start_game("restart");
    endtask

    task automatic test_three_wrong();
        for (int k = 0; k < LIVES; k++) do_attempt("wrong", 1'b0, int'($urandom_range(0, 3)), 2'd2);
        for (int k = 0; k < 3; k++) begin
            ans_valid = 1'($urandom); ans_data = 2'($urandom);
            @(negedge clk);
        end
        ans_valid = 1'b0;
        exp_v = exp_vec(M_FAILED, 0, 0, 0);
        n_checks++;
        if (obs !== exp_v) $display("FAIL failed_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_timeout();
        start_game("timeout");
        do_attempt("timeout1", 1'b1, 0, 2'd0);
        do_attempt("timeout2", 1'b1, 0, 2'd0);
    endtask

    task automatic test_simultaneous();
        do_attempt("simul", 1'b0, TIMEOUT - 1, 2'(key[m_q]));
    endtask

    task automatic test_reset_midgame();
        start = 1'b1;
        while (m_q < 3) do_attempt("busy_start", 1'b0, int'($urandom_range(0, 5)), 2'(key[m_q]));
        reset = 1'b1; ans_valid = 1'b1; ans_data = 2'(key[m_q]);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; ans_valid = 1'b0;
        exp_v = exp_vec(M_IDLE, 0, LIVES, 0);
        n_checks++;
        if (obs !== exp_v) $display("FAIL midgame_reset: got %h expected %h", obs, exp_v);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) $display("FAIL midgame_reset_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_random_games();
        int guard;
        bit to;
        logic [1:0] v;
        for (int g = 0; g < 10; g++) begin
            start_game("random");
            guard = 0;
            while (m_mode == M_ASK && guard < 40) begin
                to = ($urandom_range(0, 5) == 0);
                v  = ($urandom_range(0, 9) < 7) ? 2'(key[m_q]) : 2'($urandom);
                do_attempt("random", to, int'($urandom_range(0, TIMEOUT - 1)), v);
                guard++;
            end
            n_checks++;
            if (m_mode == M_ASK) $display("FAIL random_game_end: game %0d still running after %0d attempts", g, guard);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; ans_valid = 1'b0; ans_data = 2'd0;
        m_q = 0; m_lives = LIVES; m_score = 0; m_mode = M_IDLE;
        @(negedge clk);
        test_reset();
        test_perfect_game();
        test_restart_from_solved();
        test_three_wrong();
        test_timeout();
        test_simultaneous();
        test_reset_midgame();
        test_random_games();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
